// File: rtl/bus_timer_pkg.sv
// Shared types and constants for the bus_timer block: FSM states,
// register offsets, CTRL bit positions, mode codes and a byte-lane merge helper.
package bus_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// Data-bus view of one bus_timer instance.
// master: core side drives addr/we/byteen/wdata; slave: timer returns rdata/hit.
interface bus_timer_if;

    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output addr, we, byteen, wdata,
        input  rdata, hit
    );

    modport slave (
        input  addr, we, byteen, wdata,
        output rdata, hit
    );

endinterface

// File: rtl/bus_timer_prescaler.sv
// Tick generator: counter runs 0..PRESCALE-1 while run is high, cleared otherwise.
// Ports: clk, reset (sync, active-high), run (in), tick (out, high at PRESCALE-1).
module bus_timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with irq. Ports: clk, reset (sync, active-high),
// bus (bus_timer_if.slave), irq. Optional prescaler: macro BUS_TIMER_PRESCALE_EN.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h0000_7F00,
    parameter int          PRESCALE = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_timer_if.slave    bus,
    output logic          irq
);

    state_t      state;
    state_t      state_next;
    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic [1:0]  off;
    logic        wr;
    logic        ctrl_wr;
    logic        tick;

    logic        load;
    logic        dec;
    logic        expire;
    logic        rearm;
    logic        stop;

    assign off     = bus.addr[3:2];
    assign bus.hit = (bus.addr[31:4] == BASE[31:4]);
    assign wr      = bus.we & bus.hit;
    assign ctrl_wr = wr && (off == OFF_CTRL) && (bus.byteen != 4'b0);

`ifdef BUS_TIMER_PRESCALE_EN
    bus_timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (state == CNT),
        .tick  (tick)
    );
`else
    // No prescaler: every cycle is a tick (PRESCALE is >=1 when legal).
    assign tick = (PRESCALE >= 1);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        dec        = 1'b0;
        expire     = 1'b0;
        rearm      = 1'b0;
        stop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl.en) state_next = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl.en) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (count == 32'd0) begin
                        expire     = 1'b1;
                        state_next = INT;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            INT: begin
                if (ctrl.mode == MODE_RELOAD) begin
                    rearm      = 1'b1;
                    state_next = LOAD;
                end else begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (load)     count <= preset;
            else if (dec) count <= count - 32'd1;

            // A bus write to CTRL overrides the FSM's one-shot EN clear.
            if (stop) ctrl.en <= 1'b0;
            if (wr && off == OFF_CTRL && bus.byteen[0]) begin
                ctrl <= '{
                    im:   bus.wdata[CTRL_IM],
                    mode: bus.wdata[CTRL_MODE +: 2],
                    en:   bus.wdata[CTRL_EN]
                };
            end

            if (wr && off == OFF_PRESET) begin
                preset <= byte_merge(preset, bus.wdata, bus.byteen);
            end

            // Expiry set wins over a same-edge CTRL-write clear.
            if (expire)                pending <= 1'b1;
            else if (rearm || ctrl_wr) pending <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = '0;
        unique case (off)
            OFF_CTRL:   bus.rdata = {28'b0, ctrl};
            OFF_PRESET: bus.rdata = preset;
            OFF_COUNT:  bus.rdata = count;
            OFF_RSVD:   bus.rdata = '0;
            default:    bus.rdata = '0;
        endcase
    end

    assign irq = pending & ctrl.im;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: timeline-based reference model,
// directed scenarios plus randomized bus traffic.
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef BUS_TIMER_PRESCALE_EN
    localparam longint Q = 4;
`else
    localparam longint Q = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic irq;

    bus_timer_if bus ();

    bus_timer #(
        .BASE     (BASE),
        .PRESCALE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a run is described by the edge it entered LOAD
    // (m_start) and the snapshot length m_len; count follows from elapsed time.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pend;
    bit          m_active;
    bit          m_expired;
    longint      m_start;
    longint      m_len;
    longint      n_edge = 0;

    function automatic logic [31:0] merge(input logic [31:0] cur,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {28'b0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit          in_win, wr, cwr, set_p, clr_p;
        logic [3:0]  nctrl;
        logic [31:0] ncount;
        longint      rel, c, k;
        n_edge++;
        if (reset) begin
            m_ctrl = '0; m_preset = '0; m_count = '0;
            m_pend = 0; m_active = 0; m_expired = 0;
            return;
        end
        in_win = (bus.addr[31:4] == BASE[31:4]);
        wr     = bus.we && in_win;
        cwr    = wr && bus.addr[3:2] == 2'd0 && bus.byteen != 4'b0;
        set_p  = 0;
        clr_p  = 0;
        nctrl  = m_ctrl;
        ncount = m_count;
        if (!m_active) begin
            if (m_ctrl[0]) begin
                m_active = 1; m_start = n_edge; m_expired = 0;
            end
        end else if (m_expired) begin
            m_expired = 0;
            if (m_ctrl[2:1] == 2'b01) begin
                m_start = n_edge; clr_p = 1;
            end else begin
                m_active = 0; nctrl[0] = 1'b0;
            end
        end else begin
            rel = n_edge - m_start;
            if (rel == 1) begin
                ncount = m_preset;
                m_len  = longint'(m_preset);
            end else if (!m_ctrl[0]) begin
                m_active = 0;
            end else begin
                c = rel - 2;
                if (c % Q == Q - 1) begin
                    k = c / Q;
                    if (k == m_len) begin
                        m_expired = 1; set_p = 1;
                    end else begin
                        ncount = 32'(m_len - k - 1);
                    end
                end
            end
        end
        if (wr && bus.addr[3:2] == 2'd0 && bus.byteen[0]) nctrl = bus.wdata[3:0];
        if (wr && bus.addr[3:2] == 2'd1) m_preset = merge(m_preset, bus.wdata, bus.byteen);
        if (set_p)             m_pend = 1;
        else if (clr_p || cwr) m_pend = 0;
        m_ctrl  = nctrl;
        m_count = ncount;
    endtask

    task automatic cyc(input bit r, input logic [31:0] a, input bit w,
                       input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        reset = r; bus.addr = a; bus.we = w; bus.byteen = be; bus.wdata = d;
        e.rdata = model_rdata(a);
        e.hit   = (a[31:4] == BASE[31:4]);
        e.irq   = m_pend & m_ctrl[3];
        exp_q.push_back(e);
    endtask

    task automatic rd(input int off);
        cyc(0, BASE + 32'(off * 4), 0, 4'h0, 32'h0);
    endtask

    task automatic wr(input int off, input logic [3:0] be, input logic [31:0] d);
        cyc(0, BASE + 32'(off * 4), 1, be, d);
    endtask

    task automatic chk(input string nm, input int sel, input logic [31:0] exp);
        logic [31:0] act;
        @(negedge clk);
        if (sel == 0)      act = bus.rdata;
        else if (sel == 1) act = 32'(bus.hit);
        else               act = 32'(irq);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.rdata !== e.rdata || bus.hit !== e.hit || irq !== e.irq) begin
                    fails++;
                    $display("FAIL sb t=%0t: rdata %h hit %b irq %b expected %h %b %b",
                             $time, bus.rdata, bus.hit, irq, e.rdata, e.hit, e.irq);
                end
            end
        end
    end

    initial begin
        int pulses;
        reset = 1; bus.addr = BASE; bus.we = 0; bus.byteen = 0; bus.wdata = 0;
        cyc(1, BASE, 0, 0, 0);
        cyc(0, BASE, 0, 0, 0);

        for (int o = 0; o < 4; o++) begin
            rd(o);
            chk("rst_rdata", 0, 32'h0);
            chk("rst_hit", 1, 32'h1);
        end
        cyc(0, BASE + 32'h10, 0, 0, 0);
        chk("miss_hit", 1, 32'h0);

`ifndef BUS_TIMER_PRESCALE_EN
        wr(1, 4'hF, 32'd5);
        wr(0, 4'hF, 32'h9);
        rd(2);
        rd(2);
        for (int k = 5; k >= 0; k--) begin
            rd(2);
            chk("oneshot_cnt", 0, 32'(k));
        end
        rd(2);
        chk("oneshot_irq", 2, 32'h1);
        rd(0);
        chk("oneshot_en_clr", 0, 32'h8);
        chk("oneshot_irq_hold", 2, 32'h1);
        wr(0, 4'hF, 32'h0);
        rd(0);
        chk("irq_clr", 2, 32'h0);

        wr(1, 4'hF, 32'd2);
        wr(0, 4'hF, 32'hB);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            rd(2);
            @(negedge clk);
            if (irq === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 3) begin
            fails++;
            $display("FAIL reload_pulses: got %0d expected 3", pulses);
        end
        wr(0, 4'hF, 32'h0);

        wr(1, 4'hF, 32'h0);
        wr(1, 4'b0100, 32'h00AB_0000);
        rd(1);
        chk("byte_preset", 0, 32'h00AB_0000);
        wr(2, 4'hF, 32'hFFFF_FFFF);
        rd(2);

        wr(1, 4'hF, 32'd1);
        wr(0, 4'hF, 32'h1);
        for (int i = 0; i < 8; i++) rd(2);
        chk("masked_irq", 2, 32'h0);
        wr(0, 4'hF, 32'h8);
        rd(0);
        chk("unmask_cleared", 2, 32'h0);

        wr(1, 4'hF, 32'd0);
        wr(0, 4'hF, 32'h9);
        rd(2);
        rd(2);
        rd(2);
        chk("p0_pre", 2, 32'h0);
        rd(2);
        chk("p0_int", 2, 32'h1);

        wr(1, 4'hF, 32'd20);
        wr(0, 4'hF, 32'h9);
        for (int i = 0; i < 15; i++) rd(2);
        cyc(1, BASE + 32'h8, 0, 0, 0);
        chk("pre_rst_cnt", 0, 32'd7);
        rd(2);
        chk("post_rst_cnt", 0, 32'h0);
        chk("post_rst_irq", 2, 32'h0);
`else
        begin
            logic [31:0] prev;
            int          last;
            int          nchg;
            wr(1, 4'hF, 32'd3);
            wr(0, 4'hF, 32'h1);
            prev = 32'h0; last = -1; nchg = 0;
            for (int i = 0; i < 30; i++) begin
                rd(2);
                @(negedge clk);
                if (bus.rdata !== prev) begin
                    if (nchg > 0) begin
                        tests++;
                        if (i - last != 4) begin
                            fails++;
                            $display("FAIL psc_gap: got %0d expected 4", i - last);
                        end
                    end
                    nchg++; last = i; prev = bus.rdata;
                end
            end
            wr(0, 4'hF, 32'h0);
        end
`endif

        for (int i = 0; i < 600; i++) begin
            int          r;
            int          o;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            o = int'($urandom_range(0, 3));
            if (r < 2) begin
                cyc(1, BASE, 0, 0, 0);
            end else if (r < 40) begin
                if (o == 1) d = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 6);
                else        d = $urandom;
                wr(o, 4'($urandom), d);
            end else if (r < 45) begin
                cyc(0, BASE + 32'h10 + ($urandom & 32'hFFF0), 1, 4'hF, $urandom);
            end else begin
                rd(o);
            end
        end

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
